ztex_host_port: RTL and testbench

- Host-side master for the ZTEX byte-wide miner port: drives `rd_clk`/`read[7:0]` to load a 352-bit work unit and `wr_start`/`wr_clk` to read back the 128-bit result word.
- Sits in bench/bridge FPGAs and host emulators, and talks to the miner top through level-toggle strobes.
- The miner samples every strobe through a 4-deep synchroniser, so every timing below is expressed as cycle counts of `clk`.

---
 rtl/ztex_host_port_if.sv | 47 ++++
 rtl/ztex_host_port.sv | 227 ++++++++++++++++++++++
 tb/tb_ztex_host_port.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ztex_host_port_if.sv
// Bus bundle for ztex_host_port: job/readback handshakes, result fields and the miner byte port.
// gn_new exists only when ZTEX_AUTOPOLL_EN is defined.
interface ztex_host_port_if;
    logic         job_valid;
    logic [351:0] job_data;
    logic         job_ready;
    logic         rd_req;
    logic         rd_ready;
    logic         res_valid;
    logic [31:0]  res_golden_a;
    logic [31:0]  res_nonce;
    logic [31:0]  res_hash;
    logic [31:0]  res_golden_b;
    logic         busy;
    logic         rd_clk;
    logic [7:0]   read;
    logic         wr_start;
    logic         wr_clk;
    logic [7:0]   write;

    // slave = the host port itself; master = the job source plus miner model driving it
`ifdef ZTEX_AUTOPOLL_EN
    logic         gn_new;

    modport slave (
        input  job_valid, job_data, rd_req, write,
        output job_ready, rd_ready, res_valid, res_golden_a, res_nonce, res_hash,
               res_golden_b, busy, rd_clk, read, wr_start, wr_clk, gn_new
    );
    modport master (
        output job_valid, job_data, rd_req, write,
        input  job_ready, rd_ready, res_valid, res_golden_a, res_nonce, res_hash,
               res_golden_b, busy, rd_clk, read, wr_start, wr_clk, gn_new
    );
`else
    modport slave (
        input  job_valid, job_data, rd_req, write,
        output job_ready, rd_ready, res_valid, res_golden_a, res_nonce, res_hash,
               res_golden_b, busy, rd_clk, read, wr_start, wr_clk
    );
    modport master (
        output job_valid, job_data, rd_req, write,
        input  job_ready, rd_ready, res_valid, res_golden_a, res_nonce, res_hash,
               res_golden_b, busy, rd_clk, read, wr_start, wr_clk
    );
`endif
endinterface

// File: rtl/ztex_host_port.sv
// Host-side master for the ZTEX byte-wide miner port: sends 44-byte work units, reads 16-byte results.
// Optional macro ZTEX_AUTOPOLL_EN adds periodic automatic readback and the gn_new output.
module ztex_host_port #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 8,
    parameter int unsigned START_CYC   = 4,
    parameter int unsigned LAT_CYC     = 12,
    parameter int unsigned POLL_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    ztex_host_port_if.slave  bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] W_SETUP  = 3'd1;
    localparam logic [2:0] W_TOGGLE = 3'd2;
    localparam logic [2:0] W_HOLD   = 3'd3;
    localparam logic [2:0] R_START  = 3'd4;
    localparam logic [2:0] R_WAIT   = 3'd5;
    localparam logic [2:0] R_SAMPLE = 3'd6;

    localparam int unsigned MAX_A   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_B   = (START_CYC > LAT_CYC) ? START_CYC : LAT_CYC;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_MAX = (MAX_C > POLL_PERIOD) ? MAX_C : POLL_PERIOD;
    localparam int          CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
    localparam logic [CW-1:0] LAT_LAST   = CW'(LAT_CYC - 1);
    localparam logic [5:0]    JOB_BYTES  = 6'd44;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_byte_cnt;
    logic [3:0]    r_res_idx;
    logic          r_rd_clk;
    logic          r_wr_clk;
    logic          r_wr_start;
    logic [7:0]    r_read;
    logic          r_res_valid;
    logic [31:0]   r_res_golden_a;
    logic [31:0]   r_res_nonce;
    logic [31:0]   r_res_hash;
    logic [31:0]   r_res_golden_b;
    logic          r_rst_meta;
    logic          r_rst_sync;
    logic [351:0]  r_sreg;
    logic [119:0]  r_rword;

    logic          w_job_ready;
    logic          w_rd_ready;
    logic          w_job_go;
    logic          w_rd_go;
    logic [127:0]  w_rword_next;

    // Reset asserts asynchronously but handshakes open only after a synchronised release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_job_ready  = (r_state == IDLE) && r_rst_sync;
    assign w_rd_ready   = w_job_ready && !bus.job_valid;
    assign w_job_go     = w_job_ready && bus.job_valid;
    assign w_rword_next = {bus.write, r_rword};

`ifdef ZTEX_AUTOPOLL_EN
    logic [CW-1:0] r_poll_cnt;
    logic          r_poll_pend;
    logic          r_gn_new;

    assign w_rd_go    = w_rd_ready && (bus.rd_req || r_poll_pend);
    assign bus.gn_new = r_gn_new;

    // Any issued readback satisfies a pending poll and restarts the interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b0;
        end else if (w_rd_go) begin
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b0;
        end else if (r_poll_cnt == CW'(POLL_PERIOD - 1)) begin
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b1;
        end else begin
            r_poll_cnt  <= r_poll_cnt + 1'b1;
        end
    end
`else
    assign w_rd_go = w_rd_ready && bus.rd_req;
`endif

    // NOTE: wide datapath registers carry no reset; they are always loaded before being observed.
    always_ff @(posedge clk) begin
        if (w_job_go)
            r_sreg <= bus.job_data;
        else if (r_state == W_TOGGLE)
            r_sreg <= {8'h00, r_sreg[351:8]};
        if (r_state == R_SAMPLE)
            r_rword <= w_rword_next[127:8];
    end

    // NOTE: non-blocking assignments only, so every branch sees pre-edge state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_byte_cnt     <= '0;
            r_res_idx      <= '0;
            r_rd_clk       <= 1'b0;
            r_wr_clk       <= 1'b0;
            r_wr_start     <= 1'b0;
            r_read         <= '0;
            r_res_valid    <= 1'b0;
            r_res_golden_a <= '0;
            r_res_nonce    <= '0;
            r_res_hash     <= '0;
            r_res_golden_b <= '0;
`ifdef ZTEX_AUTOPOLL_EN
            r_gn_new       <= 1'b0;
`endif
        end else begin
            r_res_valid <= 1'b0;
`ifdef ZTEX_AUTOPOLL_EN
            r_gn_new    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_job_go) begin
                        r_state    <= W_SETUP;
                        r_byte_cnt <= '0;
                        r_read     <= bus.job_data[7:0];
                    end else if (w_rd_go) begin
                        r_state    <= R_START;
                        r_res_idx  <= '0;
                        r_wr_start <= 1'b1;
                    end
                end
                W_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= W_TOGGLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                W_TOGGLE: begin
                    r_rd_clk   <= ~r_rd_clk;
                    r_byte_cnt <= r_byte_cnt + 6'd1;
                    r_cnt      <= '0;
                    r_state    <= W_HOLD;
                end
                W_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt <= '0;
                        if (r_byte_cnt == JOB_BYTES) begin
                            r_state <= IDLE;
                        end else begin
                            r_read  <= r_sreg[7:0];
                            r_state <= W_SETUP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_START: begin
                    if (r_cnt == START_LAST) begin
                        r_cnt      <= '0;
                        r_wr_start <= 1'b0;
                        r_state    <= R_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= R_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_SAMPLE: begin
                    if (r_res_idx == 4'd15) begin
                        r_res_golden_a <= w_rword_next[31:0];
                        r_res_nonce    <= w_rword_next[63:32];
                        r_res_hash     <= w_rword_next[95:64];
                        r_res_golden_b <= w_rword_next[127:96];
                        r_res_valid    <= 1'b1;
`ifdef ZTEX_AUTOPOLL_EN
                        r_gn_new <= (w_rword_next[31:0] != r_res_golden_a) &&
                                    (w_rword_next[31:0] != 32'h0);
`endif
                        r_state <= IDLE;
                    end else begin
                        r_wr_clk  <= ~r_wr_clk;
                        r_res_idx <= r_res_idx + 4'd1;
                        r_state   <= R_WAIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.job_ready    = w_job_ready;
    assign bus.rd_ready     = w_rd_ready;
    assign bus.busy         = (r_state != IDLE);
    assign bus.rd_clk       = r_rd_clk;
    assign bus.read         = r_read;
    assign bus.wr_start     = r_wr_start;
    assign bus.wr_clk       = r_wr_clk;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_golden_a = r_res_golden_a;
    assign bus.res_nonce    = r_res_nonce;
    assign bus.res_hash     = r_res_hash;
    assign bus.res_golden_b = r_res_golden_b;
endmodule

// File: tb/tb_ztex_host_port.sv
// Self-checking bench for ztex_host_port: a miner model collects job bytes and serves a result word.
// Table-driven job/readback vectors plus hand-written arbitration, mid-job reset and autopoll sequences.
module tb_ztex_host_port;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ztex_host_port_if bus();

    ztex_host_port #(
        .SETUP_CYC  (2),
        .HOLD_CYC   (8),
        .START_CYC  (4),
        .LAT_CYC    (12),
        .POLL_PERIOD(2000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Miner model: shifts in a byte on every rd_clk edge, serves outbuf LSB-first on wr_clk edges.
    logic         m_clear = 1'b1;
    logic         m_prev_rd = 1'b0, m_prev_wr = 1'b0, m_prev_ws = 1'b0;
    logic [351:0] m_inbuf = '0;
    logic [127:0] m_obuf = '0;
    logic [127:0] m_outbuf = '0;
    logic [7:0]   m_first = '0, m_last = '0;
    int           m_rd_tog = 0, m_wr_tog = 0, m_valid_cnt = 0;

    assign bus.write = m_obuf[7:0];

    always @(posedge clk) begin
        m_prev_rd <= bus.rd_clk;
        m_prev_wr <= bus.wr_clk;
        m_prev_ws <= bus.wr_start;
        if (m_clear) begin
            m_inbuf     <= '0;
            m_rd_tog    <= 0;
            m_wr_tog    <= 0;
            m_valid_cnt <= 0;
        end else begin
            if (bus.rd_clk != m_prev_rd) begin
                m_inbuf <= {bus.read, m_inbuf[351:8]};
                if (m_rd_tog == 0) m_first <= bus.read;
                m_last   <= bus.read;
                m_rd_tog <= m_rd_tog + 1;
            end
            if (bus.wr_start && !m_prev_ws) begin
                m_obuf <= m_outbuf;
            end else if (bus.wr_clk != m_prev_wr) begin
                m_obuf   <= m_obuf >> 8;
                m_wr_tog <= m_wr_tog + 1;
            end
            if (bus.res_valid) m_valid_cnt <= m_valid_cnt + 1;
        end
    end

    typedef struct {
        logic         is_job;
        logic [351:0] job;
        logic [127:0] outw;
        logic [7:0]   first_b;
        logic [7:0]   last_b;
        logic [31:0]  ga;
        logic [31:0]  nonce;
        logic [31:0]  hash;
        logic [31:0]  gb;
    } vec_t;

    localparam logic [255:0] MID1 = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
    localparam logic [95:0]  DAT1 = 96'hffff001e11f35052d554469e;
    localparam logic [255:0] MID2 = 256'hc3112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;
    localparam logic [95:0]  DAT2 = 96'h0badf00dcafebabe1234567f;
    localparam logic [127:0] OUT_A = {32'h0, 32'h12345678, 32'hdeadbeef, 32'hffbd9207};
    localparam logic [127:0] OUT_B = 128'h0123456789abcdeffedcba9876543210;

    vec_t vecs[4];

    task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic clear_model();
        @(negedge clk);
        m_clear = 1'b1;
        @(negedge clk);
        m_clear = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_job(input logic [351:0] data, input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.job_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.job_ready) timeout({name, "_job_ready"});
        bus.job_valid = 1'b1;
        bus.job_data  = data;
        @(negedge clk);
        bus.job_valid = 1'b0;
        wait_idle({name, "_job_idle"});
    endtask

    task automatic do_read(input string name);
        int n = 0;
        @(negedge clk);
        bus.rd_req = 1'b1;
        while (!bus.rd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rd_ready) timeout({name, "_rd_ready"});
        @(negedge clk);
        bus.rd_req = 1'b0;
        wait_idle({name, "_rd_idle"});
    endtask

`ifdef ZTEX_AUTOPOLL_EN
    task automatic wait_valid(input string name, output logic gn);
        int n = 0;
        gn = 1'b0;
        @(negedge clk);
        while (!bus.res_valid && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) timeout(name);
        else gn = bus.gn_new;
    endtask
`endif

    initial begin
        logic [31:0] held_ga;
        int n;

        vecs[0] = '{1'b1, {MID1, DAT1}, 128'h0, 8'h9e, 8'h22, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 352'h0, OUT_A, 8'h0, 8'h0, 32'hffbd9207, 32'hdeadbeef, 32'h12345678, 32'h0};
        vecs[2] = '{1'b1, {MID2, DAT2}, 128'h0, 8'h7f, 8'hc3, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 352'h0, OUT_B, 8'h0, 8'h0, 32'h76543210, 32'hfedcba98, 32'h89abcdef, 32'h01234567};

        bus.job_valid = 1'b0;
        bus.job_data  = '0;
        bus.rd_req    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);

        check("rst_rd_clk",    bus.rd_clk, 1'b0);
        check("rst_wr_clk",    bus.wr_clk, 1'b0);
        check("rst_wr_start",  bus.wr_start, 1'b0);
        check("rst_busy",      bus.busy, 1'b0);
        check("rst_read",      bus.read, 8'h0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_all",   {bus.res_golden_a, bus.res_nonce, bus.res_hash, bus.res_golden_b}, 128'h0);
        check("rst_job_ready", bus.job_ready, 1'b1);
        check("rst_rd_ready",  bus.rd_ready, 1'b1);

        held_ga = 32'h0;
        for (int i = 0; i < 4; i++) begin
            clear_model();
            if (vecs[i].is_job) begin
                do_job(vecs[i].job, $sformatf("v%0d", i));
                check($sformatf("v%0d_rd_toggles", i), m_rd_tog, 44);
                check($sformatf("v%0d_inbuf", i),      m_inbuf, vecs[i].job);
                check($sformatf("v%0d_first", i),      m_first, vecs[i].first_b);
                check($sformatf("v%0d_last", i),       m_last, vecs[i].last_b);
                check($sformatf("v%0d_rd_clk_par", i), bus.rd_clk, 1'b0);
                check($sformatf("v%0d_res_hold", i),   bus.res_golden_a, held_ga);
            end else begin
                m_outbuf = vecs[i].outw;
                do_read($sformatf("v%0d", i));
                check($sformatf("v%0d_golden_a", i),   bus.res_golden_a, vecs[i].ga);
                check($sformatf("v%0d_nonce", i),      bus.res_nonce, vecs[i].nonce);
                check($sformatf("v%0d_hash", i),       bus.res_hash, vecs[i].hash);
                check($sformatf("v%0d_golden_b", i),   bus.res_golden_b, vecs[i].gb);
                check($sformatf("v%0d_wr_toggles", i), m_wr_tog, 15);
                check($sformatf("v%0d_valid_cnt", i),  m_valid_cnt, 1);
                held_ga = vecs[i].ga;
            end
        end

        // Job and readback requested together: the job goes first, the readback follows.
        clear_model();
        m_outbuf = OUT_A;
        bus.job_valid = 1'b1;
        bus.job_data  = {MID2, DAT2};
        bus.rd_req    = 1'b1;
        #1;
        check("both_rd_ready",  bus.rd_ready, 1'b0);
        check("both_job_ready", bus.job_ready, 1'b1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        n = 0;
        while (!bus.rd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rd_ready) timeout("both_rd_ready_wait");
        check("both_job_toggles", m_rd_tog, 44);
        check("both_no_read_yet", m_wr_tog, 0);
        @(negedge clk);
        bus.rd_req = 1'b0;
        wait_idle("both_idle");
        check("both_inbuf",    m_inbuf, {MID2, DAT2});
        check("both_golden_a", bus.res_golden_a, 32'hffbd9207);
        check("both_wr_tog",   m_wr_tog, 15);
        check("both_valid",    m_valid_cnt, 1);

        // Reset partway through a job: everything returns to reset values immediately.
        clear_model();
        bus.job_valid = 1'b1;
        bus.job_data  = {MID1, DAT1};
        @(negedge clk);
        bus.job_valid = 1'b0;
        n = 0;
        while (m_rd_tog < 21 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (m_rd_tog < 21) timeout("mid_rst_wait");
        check("mid_rd_clk_before", bus.rd_clk, 1'b1);
        m_clear = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd_clk", bus.rd_clk, 1'b0);
        check("mid_rst_busy",   bus.busy, 1'b0);
        check("mid_rst_read",   bus.read, 8'h0);
        check("mid_rst_res_ga", bus.res_golden_a, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        m_clear = 1'b0;
        check("post_rst_job_ready", bus.job_ready, 1'b1);
        do_job({MID1, DAT1}, "post_rst");
        check("post_rst_toggles", m_rd_tog, 44);
        check("post_rst_inbuf",   m_inbuf, {MID1, DAT1});
        check("post_rst_first",   m_first, 8'h9e);

`ifdef ZTEX_AUTOPOLL_EN
        begin
            logic gn;
            m_outbuf = OUT_A;
            wait_valid("poll_first", gn);
            if (bus.res_golden_a !== 32'hffbd9207) wait_valid("poll_first_retry", gn);
            check("poll_ga",        bus.res_golden_a, 32'hffbd9207);
            check("poll_gn_first",  gn, 1'b1);
            wait_valid("poll_second", gn);
            check("poll_gn_second", gn, 1'b0);
            wait_valid("poll_third", gn);
            check("poll_gn_third",  gn, 1'b0);
            check("poll_ga_stay",   bus.res_golden_a, 32'hffbd9207);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
